// File: rtl/instr_pkg.sv
// Shared opcode/operand-type encodings for the instruction queue.
package instr_pkg;

    localparam int unsigned OPC_W = 3;

    typedef enum logic [OPC_W-1:0] {ADD, SUB, MULT, DIV, SL, SR} opcode_t;
    typedef enum logic {UNSIGNED, SIGNED} operand_type_t;

    // Encodings above SR (6, 7) are reserved and get dropped on entry.
    function automatic logic is_legal_opcode(input opcode_t opc);
        return OPC_W'(opc) <= OPC_W'(SR);
    endfunction

endpackage

// File: rtl/instruction_queue_if.sv
// Producer/consumer handshake bundle of the instruction queue.
interface instruction_queue_if
    import instr_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned INSTR_W = OPC_W + 1 + 2 * DATA_W;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    opcode_t             in_opcode;
    operand_type_t       in_op_type;
    logic [IN_W-1:0]     in_operand_a;
    logic [IN_W-1:0]     in_operand_b;
    logic                out_valid;
    logic                out_ready;
    logic [INSTR_W-1:0]  out_instr;
    logic [CNT_W-1:0]    count;
    logic                err_illegal;

    modport master (
        output flush, in_valid, in_opcode, in_op_type, in_operand_a, in_operand_b, out_ready,
        input  in_ready, out_valid, out_instr, count, err_illegal
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_op_type, in_operand_a, in_operand_b, out_ready,
        output in_ready, out_valid, out_instr, count, err_illegal
    );

endinterface

// File: rtl/operand_extend.sv
// Widens a raw operand to the datapath: sign-extend for SIGNED, zero-extend otherwise.
module operand_extend
    import instr_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DATA_W = 32
) (
    input  operand_type_t     op_type,
    input  logic [IN_W-1:0]   raw,
    output logic [DATA_W-1:0] ext
);

    generate
        if (IN_W == DATA_W) begin : g_pass
            logic unused_op_type;
            assign unused_op_type = op_type;
            assign ext = raw;
        end else begin : g_extend
            always_comb begin
                ext = {{(DATA_W-IN_W){1'b0}}, raw};
                if (op_type == SIGNED) begin
                    ext = {{(DATA_W-IN_W){raw[IN_W-1]}}, raw};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/instruction_queue.sv
// In-order instruction FIFO with operand normalisation and illegal-opcode drop.
module instruction_queue
    import instr_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DEPTH  = 32
) (
    input logic                clock,
    input logic                reset,
    instruction_queue_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef union packed {
        logic        [DATA_W-1:0] u_data;
        logic signed [DATA_W-1:0] s_data;
    } data_t;

    typedef struct packed {
        opcode_t       opc;
        operand_type_t op_type;
        data_t         op_a;
        data_t         op_b;
    } instr_t;

    instr_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               err_illegal;

    logic [DATA_W-1:0]  ext_a;
    logic [DATA_W-1:0]  ext_b;
    instr_t             new_instr;
    logic               in_ready;
    logic               out_valid;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;

    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign legal     = is_legal_opcode(bus.in_opcode);
    assign accept    = bus.in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & bus.out_ready;

    operand_extend #(.IN_W(IN_W), .DATA_W(DATA_W)) u_ext_a (
        .op_type (bus.in_op_type),
        .raw     (bus.in_operand_a),
        .ext     (ext_a)
    );

    operand_extend #(.IN_W(IN_W), .DATA_W(DATA_W)) u_ext_b (
        .op_type (bus.in_op_type),
        .raw     (bus.in_operand_b),
        .ext     (ext_b)
    );

    always_comb begin
        new_instr             = '0;
        new_instr.opc         = bus.in_opcode;
        new_instr.op_type     = bus.in_op_type;
        new_instr.op_a.u_data = ext_a;
        new_instr.op_b.u_data = ext_b;
    end

    // Storage is never reset; only pointers, count and the error flag are.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_instr;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            err_illegal <= accept & ~legal;
        end
    end

    // Head is forced to zero while empty so reset and flush present a clean bus.
    assign bus.out_instr   = out_valid ? mem[rd_ptr] : '0;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.count       = count;
    assign bus.err_illegal = err_illegal;

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(push && !in_ready));
    a_no_pop_when_empty: assert property (@(posedge clock) disable iff (reset) !(pop && !out_valid));
    a_count_bounded:     assert property (@(posedge clock) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_instruction_queue.sv
// Randomised scoreboard bench for instruction_queue against a queue-based reference model.
module tb_instruction_queue;
    import instr_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IN_W    = 16;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned INSTR_W = 4 + 2 * DATA_W;

    typedef logic [INSTR_W-1:0] word_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    instruction_queue_if #(.DATA_W(DATA_W), .IN_W(IN_W), .DEPTH(DEPTH)) bus ();

    instruction_queue #(.DATA_W(DATA_W), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int    checks    = 0;
    int    errors    = 0;
    word_t exp_q[$];
    int    exp_count = 0;
    logic  exp_err   = 1'b0;
    logic  rand_mode = 1'b0;
    logic  m_pop;
    logic  m_push;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_legal(input opcode_t opc);
        return int'(opc) < 6;
    endfunction

    // Reference extension by integer arithmetic on the operand's numeric value.
    function automatic logic [DATA_W-1:0] model_extend(input operand_type_t t, input logic [IN_W-1:0] raw);
        longint v;
        longint half;
        v    = longint'(raw);
        half = longint'(1) << (IN_W - 1);
        if (t == SIGNED && v >= half) v = v - (longint'(1) << IN_W);
        return DATA_W'(v);
    endfunction

    function automatic word_t model_entry(input opcode_t opc, input operand_type_t t,
                                          input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        return {3'(opc), 1'(t), model_extend(t, a), model_extend(t, b)};
    endfunction

    // Monitor: checks registered status each cycle and pops the scoreboard on every take.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            exp_count = 0;
            exp_err   = 1'b0;
        end else begin
            chk("count", INSTR_W'(bus.count), INSTR_W'(exp_count));
            chk("in_ready", INSTR_W'(bus.in_ready), INSTR_W'(exp_count != DEPTH));
            chk("out_valid", INSTR_W'(bus.out_valid), INSTR_W'(exp_count != 0));
            chk("err_illegal", INSTR_W'(bus.err_illegal), INSTR_W'(exp_err));
            if (!bus.out_valid) chk("idle_instr", bus.out_instr, '0);
            if (bus.flush) begin
                exp_q.delete();
                exp_count = 0;
                exp_err   = 1'b0;
            end else begin
                m_pop  = bus.out_valid && bus.out_ready;
                m_push = bus.in_valid && bus.in_ready && model_legal(bus.in_opcode);
                if (m_pop) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL head: got %0h expected nothing queued", bus.out_instr);
                    end else begin
                        chk("head", bus.out_instr, exp_q.pop_front());
                    end
                end
                if (m_push && !m_pop) exp_count++;
                if (m_pop && !m_push) exp_count--;
                exp_err = bus.in_valid && bus.in_ready && !model_legal(bus.in_opcode);
            end
        end
    end

    // Presents one instruction and returns just after the edge that accepted it.
    task automatic send(input opcode_t opc, input operand_type_t t,
                        input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
        int waited = 0;
        bus.in_valid     = 1'b1;
        bus.in_opcode    = opc;
        bus.in_op_type   = t;
        bus.in_operand_a = a;
        bus.in_operand_b = b;
        forever begin
            @(negedge clock);
            if (bus.in_ready && !reset) begin
                if (!bus.flush && model_legal(opc)) exp_q.push_back(model_entry(opc, t, a, b));
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
            if (rand_mode) bus.out_ready = 1'b1;
            waited++;
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no acceptance expected in_ready within 200 cycles");
                break;
            end
        end
    endtask

    task automatic send_rand(input logic allow_illegal);
        opcode_t opc;
        opc = opcode_t'(3'($urandom_range(0, allow_illegal ? 7 : 5)));
        send(opc, operand_type_t'(1'($urandom_range(0, 1))), IN_W'($urandom), IN_W'($urandom));
    endtask

    task automatic cycle();
        @(posedge clock); #1;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (bus.count != 0 && n < 200) begin
            cycle();
            n++;
        end
        bus.out_ready = 1'b0;
        chk("drain_empty", INSTR_W'(bus.count), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] raw7;
        raw7             = 3'd7;
        bus.flush        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.in_opcode    = ADD;
        bus.in_op_type   = UNSIGNED;
        bus.in_operand_a = '0;
        bus.in_operand_b = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_count", INSTR_W'(bus.count), '0);
        chk("rst_in_ready", INSTR_W'(bus.in_ready), INSTR_W'(1));
        chk("rst_out_valid", INSTR_W'(bus.out_valid), '0);
        chk("rst_err", INSTR_W'(bus.err_illegal), '0);
        chk("rst_instr", bus.out_instr, '0);
        #3 reset = 1'b0;
        cycle();

        // Zero extension and first-word fall-through latency.
        send(ADD, UNSIGNED, 16'hFFFF, 16'h0001);
        bus.in_valid = 1'b0;
        chk("t1_valid", INSTR_W'(bus.out_valid), INSTR_W'(1));
        chk("t1_op_a", INSTR_W'(bus.out_instr[63:32]), INSTR_W'(32'h0000FFFF));
        chk("t1_op_b", INSTR_W'(bus.out_instr[31:0]), INSTR_W'(32'h00000001));
        drain();

        // Sign extension of negative and positive extremes.
        send(SUB, SIGNED, 16'h8000, 16'h0003);
        bus.in_valid = 1'b0;
        chk("t2_neg", INSTR_W'(bus.out_instr[63:32]), INSTR_W'(32'hFFFF8000));
        chk("t2_opc", INSTR_W'(bus.out_instr[67:65]), INSTR_W'(3'd1));
        drain();
        send(ADD, SIGNED, 16'h7FFF, 16'hFFFE);
        bus.in_valid = 1'b0;
        chk("t2_pos", INSTR_W'(bus.out_instr[63:32]), INSTR_W'(32'h00007FFF));
        chk("t2_b_neg", INSTR_W'(bus.out_instr[31:0]), INSTR_W'(32'hFFFFFFFE));
        drain();

        // Fill to full, hold an extra request, then drain in order.
        for (int i = 0; i < 32; i++) send_rand(1'b0);
        bus.in_valid = 1'b0;
        chk("full_count", INSTR_W'(bus.count), INSTR_W'(32));
        chk("full_ready", INSTR_W'(bus.in_ready), '0);
        bus.in_valid  = 1'b1;
        bus.in_opcode = MULT;
        repeat (3) cycle();
        chk("full_hold", INSTR_W'(bus.count), INSTR_W'(32));
        bus.in_valid = 1'b0;
        drain();
        chk("drained_valid", INSTR_W'(bus.out_valid), '0);

        // Steady push+pop at level 5 across several pointer wraps.
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) send_rand(1'b0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_count", INSTR_W'(bus.count), INSTR_W'(5));

        // Illegal opcode: accepted, dropped, one-cycle flag.
        send(opcode_t'(raw7), UNSIGNED, 16'h1234, 16'h5678);
        bus.in_valid = 1'b0;
        chk("illegal_flag", INSTR_W'(bus.err_illegal), INSTR_W'(1));
        chk("illegal_count", INSTR_W'(bus.count), INSTR_W'(5));
        cycle();
        chk("illegal_pulse", INSTR_W'(bus.err_illegal), '0);

        // Flush at level 10 beats a simultaneous push and pop.
        for (int i = 0; i < 5; i++) send_rand(1'b0);
        bus.in_valid = 1'b0;
        chk("pre_flush", INSTR_W'(bus.count), INSTR_W'(10));
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = DIV;
        bus.out_ready = 1'b1;
        cycle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_count", INSTR_W'(bus.count), '0);
        chk("flush_valid", INSTR_W'(bus.out_valid), '0);

        // Random traffic with illegal opcodes, random consumer and occasional flush.
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            bus.out_ready = 1'b0;
            if ($urandom_range(0, 2) != 0) bus.out_ready = 1'b1;
            if (r == 0) begin
                bus.in_valid = 1'b0;
                bus.flush    = 1'b1;
                cycle();
                bus.flush    = 1'b0;
            end else if (r < 5) begin
                bus.in_valid = 1'b0;
                cycle();
            end else begin
                send_rand(1'b1);
            end
        end
        rand_mode = 1'b0;
        drain();

        // Asynchronous reset mid-stream clears everything without waiting for an edge.
        for (int i = 0; i < 6; i++) send_rand(1'b0);
        bus.in_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", INSTR_W'(bus.count), '0);
        chk("arst_valid", INSTR_W'(bus.out_valid), '0);
        chk("arst_ready", INSTR_W'(bus.in_ready), INSTR_W'(1));
        chk("arst_instr", bus.out_instr, '0);
        chk("arst_err", INSTR_W'(bus.err_illegal), '0);
        exp_q.delete();
        exp_count = 0;
        exp_err   = 1'b0;
        cycle();
        #3 reset = 1'b0;
        cycle();
        send(SL, SIGNED, 16'hFF00, 16'h0080);
        bus.in_valid = 1'b0;
        chk("post_rst_a", INSTR_W'(bus.out_instr[63:32]), INSTR_W'(32'hFFFFFF00));
        drain();
        chk("model_empty", INSTR_W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
